// File: rtl/button_debouncer.sv
// button_debouncer: two-flop sync, polarity fix and counter debounce per button.
// Optional press pulse built only when BUTTON_DEBOUNCE_PRESS_PULSE_EN is defined.
module button_debouncer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_level,
   output logic [WIDTH-1:0] btn_press
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WIDTH-1:0] IDLE =
      ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] pressed_s;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] differ;
   logic [WIDTH-1:0] accept;
   logic [CW-1:0]    cnt [WIDTH];

   // Sync flops reset to the released pin level so no false press appears.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= IDLE;
         sync2 <= IDLE;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   assign pressed_s = ACTIVE_LOW ? ~sync2 : sync2;

   always_comb begin
      differ = '0;
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         differ[i] = pressed_s[i] != stable[i];
         accept[i] = differ[i] && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (reset) begin
            stable[i] <= 1'b0;
            cnt[i]    <= '0;
         end else if (!differ[i]) begin
            cnt[i]    <= '0;
         end else if (accept[i]) begin
            stable[i] <= pressed_s[i];
            cnt[i]    <= '0;
         end else begin
            cnt[i]    <= cnt[i] + CW'(1);
         end
      end
   end

   assign btn_level = stable;

`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
   logic [WIDTH-1:0] press_q;

   // Fires on the same edge that stable rises, never on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         press_q <= '0;
      end else begin
         press_q <= accept & pressed_s;
      end
   end

   assign btn_press = press_q;
`else
   assign btn_press = '0;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the raw push-button inputs from the board before they reach the Avalon PIO input port that the Nios II software polls. Per button: two-flop synchronizer, polarity normalisation, and a counter-based debouncer that only accepts a level held stable for a configurable number of clocks. The debounced, active-high levels drive the PIO's 4-bit `in_port` directly. An optional one-cycle press pulse is provided for future edge-capture or interrupt use.

## Interface

- `WIDTH`, 4: number of buttons handled; all per-button logic is replicated.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable clocks required to accept a new level (10 ms at 50 MHz); legal range ≥ 1.
- `ACTIVE_LOW`, 1: 1 = raw input reads 0 when pressed (DE-board KEY), 0 = reads 1 when pressed.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous reset, active-high.
- `btn_raw`  in  WIDTH  asynchronous raw button pins.
- `btn_level`  out  WIDTH  debounced level, 1 = pressed; connects to PIO `in_port`.
- `btn_press`  out  WIDTH  one-cycle pulse per accepted press.

## Operation

- Synchronizer per bit: `sync1 <= btn_raw`, `sync2 <= sync1`. If `ACTIVE_LOW`=1, invert after `sync2`, giving `pressed_s` (1 = pressed).
- Per-bit state: `stable` (drives `btn_level`) and counter `cnt`.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit. The counter never wraps.
- Per-bit update on each clock when not in reset:
  - If `pressed_s == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= pressed_s` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Glitch rule: any single cycle where `pressed_s` returns to `stable` clears `cnt`, so the stability window restarts from zero.
- Bits are fully independent. Simultaneous changes on several bits are debounced in parallel with no interaction.
- `btn_press[i]` is registered. It is 1 for exactly the cycle in which `stable[i]` transitions 0→1, coincident with the `btn_level` rise. A release (1→0) produces no pulse.
- `btn_level` is a level signal. The downstream PIO samples it every clock, so no handshake is required.

## Timing

- Reset values:
  - `sync1`/`sync2` load the released raw level: all-ones if `ACTIVE_LOW`=1, else zeros.
  - `stable` = 0, `cnt` = 0.
  - `btn_level` = 0, `btn_press` = 0.
- Reset asserted mid-debounce discards the partial count. After release, a button still held is re-accepted only after the full window.
- Latency: a raw change first captured by `sync1` at edge t, and held, appears on `btn_level` (and `btn_press`) after edge t + DEBOUNCE_CYCLES + 1.
- `DEBOUNCE_CYCLES`=1: a level is accepted after edge t+2, i.e. synchronizer delay only.
- A bounce shorter than DEBOUNCE_CYCLES clocks never changes `btn_level`.
- Minimum accepted pulse width on the pin: DEBOUNCE_CYCLES clocks.
- All outputs are registered. There is no combinational path from `btn_raw` to any output.

## Configuration

- Macro: `BUTTON_DEBOUNCE_PRESS_PULSE_EN`.
- Defined: `btn_press` generation logic is built as described in Operation.
- Undefined: the logic is omitted and `btn_press` is tied to all zeros. The port still exists, so the top level and bench need no change.
- `btn_level` behaviour is identical in both builds.

## Test plan

Bench uses `WIDTH`=4, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1.

1. Reset with `btn_raw`=4'hF, hold 10 cycles → `btn_level`=0, `btn_press`=0 throughout; drive `reset` high for 1 cycle mid-run → same.
2. Drive `btn_raw[0]` 1→0 and hold → `btn_level`=4'h1 exactly 5 edges after the first capture edge; `btn_press`=4'h1 for that single cycle only (macro defined).
3. Bounce `btn_raw[1]` low 3 cycles, high 1, low 3, high → `btn_level[1]` stays 0; `btn_press` stays 0.
4. Hold `btn_raw[2]` low until `btn_level`=4'h4, then release high → `btn_level[2]` returns to 0 after 5 edges; no `btn_press` on release.
5. Press bits 0 and 3 on the same edge → `btn_level`=4'h9 on the same cycle, `btn_press`=4'h9 for one cycle. Assert `reset` two cycles into a later press of bit 1 → count is discarded, and `btn_level[1]` rises 5 edges after reset deasserts.
6. Rebuild without `BUTTON_DEBOUNCE_PRESS_PULSE_EN` and rerun scenario 2 → `btn_level` timing is identical; `btn_press` stays 0.
